// File: rtl/counter_ctrl_pkg.sv
// Shared definitions for the counter command sequencer.
//   - Default counter width and wrap-count field width.
//   - Two-bit FSM state encoding (ST_*), plus an enum built on it so the
//     state register and its debug output carry readable names.
package counter_ctrl_pkg;

  localparam int DEF_WIDTH  = 4;
  localparam int DEF_WRAP_W = 4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_LOAD = ST_LOAD,
    S_WAIT = ST_WAIT,
    S_DONE = ST_DONE
  } state_t;

endpackage

// File: rtl/count_wrap_detect.sv
// Wrap-event detector for the up counter's d_out.
// Ports:
//   clk, rst  : rising-edge clock, asynchronous active-high reset
//   clear     : invalidates the stored previous sample (driven during LOAD)
//   sample    : capture cnt as the previous sample this cycle (WAIT)
//   cnt       : counter d_out
//   wrap      : combinational single-bit event, previous == all-ones and
//               current == 0, only when the previous sample is valid
module count_wrap_detect
  import counter_ctrl_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             sample,
  input  logic [WIDTH-1:0] cnt,
  output logic             wrap
);

  logic [WIDTH-1:0] prev_cnt;
  logic             prev_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_cnt   <= '0;
      prev_valid <= 1'b0;
    end else if (clear) begin
      // The first WAIT cycle must not compare against whatever the counter
      // held before the load, or a pre-load value of all-ones followed by a
      // start of zero would look like a wrap.
      prev_valid <= 1'b0;
    end else if (sample) begin
      prev_cnt   <= cnt;
      prev_valid <= 1'b1;
    end
  end

  assign wrap = prev_valid && (prev_cnt == '1) && (cnt == '0);

endmodule

// File: rtl/up_counter_load_seq.sv
// Command sequencer in front of the up counter's load/d_in inputs.
// A preload command is accepted, load is pulsed for one cycle with the start
// value, then the counter output is watched for a programmed number of
// all-ones -> zero wrap events; completion is flagged by a one-cycle done.
//
// Handshake: a command transfers on a rising edge where cmd_valid and
// cmd_ready are both high. cmd_ready is high only in IDLE and does not depend
// on cmd_valid; cmd_valid outside IDLE is simply ignored (nothing buffered).
//
// Ports:
//   clk, rst           : rising-edge clock, asynchronous active-high reset
//   cmd_valid/cmd_ready: command handshake
//   cmd_start          : preload value, captured into d_in on accept
//   cmd_wraps          : wrap events to wait for (0 = none)
//   abort              : cancel a command in LOAD or WAIT (no done)
//   load, d_in         : counter load strobe and preload data
//   cnt                : counter d_out
//   busy               : command in flight (LOAD or WAIT)
//   wrap_seen          : wraps counted for the current command
//   done               : one-cycle completion pulse
//   state              : current FSM state, for observation
module up_counter_load_seq
  import counter_ctrl_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int WRAP_W = DEF_WRAP_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [WIDTH-1:0]  cmd_start,
  input  logic [WRAP_W-1:0] cmd_wraps,
  input  logic              abort,
  output logic              load,
  output logic [WIDTH-1:0]  d_in,
  input  logic [WIDTH-1:0]  cnt,
  output logic              busy,
  output logic [WRAP_W-1:0] wrap_seen,
  output logic              done,
  output state_t            state
);

  state_t            state_q;
  state_t            state_d;
  logic [WRAP_W-1:0] wraps_q;
  logic              accept;
  logic              wrap;
  logic              count_wrap;
  logic              last_wrap;

  assign accept     = cmd_valid && cmd_ready;
  // Abort takes priority over a coincident wrap event.
  assign count_wrap = (state_q == S_WAIT) && wrap && !abort;
  assign last_wrap  = (wrap_seen + WRAP_W'(1)) == wraps_q;
  assign state      = state_q;

  count_wrap_detect #(
    .WIDTH(WIDTH)
  ) u_wrap_detect (
    .clk   (clk),
    .rst   (rst),
    .clear (state_q == S_LOAD),
    .sample(state_q == S_WAIT),
    .cnt   (cnt),
    .wrap  (wrap)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cmd_ready = 1'b0;
    load      = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state_q)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_d = S_LOAD;
      end
      S_LOAD: begin
        load = 1'b1;
        busy = 1'b1;
        if (abort)              state_d = S_IDLE;
        else if (wraps_q == '0) state_d = S_DONE;
        else                    state_d = S_WAIT;
      end
      S_WAIT: begin
        busy = 1'b1;
        if (abort)                  state_d = S_IDLE;
        else if (wrap && last_wrap) state_d = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // d_in keeps the last start value after LOAD; wrap_seen holds its final
  // count until the next accept clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d_in      <= '0;
      wraps_q   <= '0;
      wrap_seen <= '0;
    end else if (accept) begin
      d_in      <= cmd_start;
      wraps_q   <= cmd_wraps;
      wrap_seen <= '0;
    end else if (count_wrap) begin
      wrap_seen <= wrap_seen + WRAP_W'(1);
    end
  end

endmodule

// File: tb/tb_up_counter_load_seq.sv
// Bench for up_counter_load_seq with a behavioural 4-bit up counter attached.
// Expected behaviour comes from the timing rules: load in cycle 1, wrap k
// detected in cycle 3 + (15 - start) + 16*k, done one cycle after the last
// wrap (cycle 2 when no wraps are requested), abort ends the command at once.
module tb_up_counter_load_seq;

  localparam int MAX  = 15;
  localparam int SPAN = 16;

  logic       clk;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] cmd_start;
  logic [3:0] cmd_wraps;
  logic       abort;
  logic       load;
  logic [3:0] d_in;
  logic [3:0] cnt;
  logic       busy;
  logic [3:0] wrap_seen;
  logic       done;
  logic [1:0] state;

  logic       cnt_force;
  logic [3:0] cnt_force_val;

  int n_checks;
  int n_pass;
  logic [3:0] exp_q[$];

  up_counter_load_seq #(
    .WIDTH (4),
    .WRAP_W(4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_start(cmd_start),
    .cmd_wraps(cmd_wraps),
    .abort    (abort),
    .load     (load),
    .d_in     (d_in),
    .cnt      (cnt),
    .busy     (busy),
    .wrap_seen(wrap_seen),
    .done     (done),
    .state    (state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counter being sequenced: free-running, loads on load, presettable.
  always @(posedge clk) begin
    if (cnt_force)  cnt <= cnt_force_val;
    else if (load)  cnt <= d_in;
    else            cnt <= cnt + 4'd1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, got=running exp=finished");
    $fatal(1);
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
  endtask

  // ---------------- reference model ----------------
  function automatic int det_cycle(input int start, input int j);
    return 3 + (MAX - start) + SPAN * j;
  endfunction

  function automatic int done_cycle(input int start, input int wraps);
    return (wraps == 0) ? 2 : 4 + (MAX - start) + SPAN * (wraps - 1);
  endfunction

  // Wraps counted before cycle c (detections in cycle c land at its end).
  function automatic int wraps_before(input int start, input int wraps, input int c);
    int n;
    n = 0;
    for (int j = 0; j < wraps; j++) if (det_cycle(start, j) < c) n++;
    return n;
  endfunction

  // ---------------- drivers ----------------
  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check("idle_load", load, 0);
      check("idle_ready", cmd_ready, 1);
      check("idle_done", done, 0);
    end
  endtask

  // Issues one command from an IDLE negedge and checks every cycle until the
  // block is idle again. abort_at / rst_at: cycle number, 0 = not used.
  // noise: 0 none, 1 random cmd_valid while busy, 2 cmd_valid held high.
  task automatic run_cmd(input int start, input int wraps, input int preset,
                         input int abort_at, input int rst_at, input int noise);
    int dc, last, cut, exp_ws;
    logic exp_busy, exp_done;
    dc   = done_cycle(start, wraps);
    last = dc;
    if (abort_at > 0) last = abort_at;
    if (rst_at > 0)   last = rst_at;
    if (rst_at > 0)        exp_q.push_back(4'd0);
    else if (abort_at > 0) exp_q.push_back(4'(wraps_before(start, wraps, abort_at)));
    else                   exp_q.push_back(4'(wraps));

    check("ready_pre", cmd_ready, 1);
    cmd_valid     = 1'b1;
    cmd_start     = 4'(start);
    cmd_wraps     = 4'(wraps);
    abort         = 1'b0;
    cnt_force     = 1'b1;
    cnt_force_val = 4'(preset);

    for (int c = 1; c <= last + 1; c++) begin
      @(negedge clk);
      cnt_force = 1'b0;
      cut = (abort_at > 0 && c > abort_at) ? abort_at : c;
      exp_busy = (abort_at > 0) ? (c <= abort_at) : (c < dc);
      exp_done = (abort_at == 0) && (c == dc);
      exp_ws   = wraps_before(start, wraps, cut);
      check("load", load, (c == 1));
      check("busy", busy, exp_busy);
      check("done", done, exp_done);
      check("cmd_ready", cmd_ready, !exp_busy && !exp_done);
      check("wrap_seen", wrap_seen, exp_ws);
      check("d_in", d_in, start);

      if (c == rst_at) begin
        cmd_valid = 1'b0;
        abort     = 1'b0;
        rst       = 1'b1;
        #1;
        check("rst_ready", cmd_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_load", load, 0);
        check("rst_done", done, 0);
        check("rst_d_in", d_in, 0);
        check("rst_wrap_seen", wrap_seen, exp_q.pop_front());
        @(negedge clk);
        rst = 1'b0;
        return;
      end

      if (c <= last) begin
        abort = (c == abort_at);
        if (noise == 2)      cmd_valid = 1'b1;
        else if (noise == 1) cmd_valid = 1'($urandom_range(0, 1));
        else                 cmd_valid = 1'b0;
        if (noise != 0) begin
          cmd_start = 4'($urandom_range(0, 15));
          cmd_wraps = 4'($urandom_range(0, 15));
        end
      end else begin
        cmd_valid = 1'b0;
        abort     = 1'b0;
        check("final_wrap_seen", wrap_seen, exp_q.pop_front());
      end
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int s, w, a, dc;
    n_checks      = 0;
    n_pass        = 0;
    rst           = 1'b1;
    cmd_valid     = 1'b0;
    cmd_start     = 4'd0;
    cmd_wraps     = 4'd0;
    abort         = 1'b0;
    cnt_force     = 1'b1;
    cnt_force_val = 4'd0;

    @(negedge clk);
    @(negedge clk);
    check("reset_ready", cmd_ready, 1);
    check("reset_load", load, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_d_in", d_in, 0);
    check("reset_wrap_seen", wrap_seen, 0);
    rst       = 1'b0;
    cnt_force = 1'b0;

    idle_cycles(4);

    run_cmd(14, 1, 3, 0, 0, 0);    // done in cycle 5
    run_cmd(15, 0, 9, 0, 0, 0);    // done in cycle 2
    idle_cycles(1);
    run_cmd(0, 2, 15, 0, 0, 0);    // counter at 15 before load; done in cycle 35
    run_cmd(12, 3, 7, 22, 0, 2);   // abort on the second wrap, cmd_valid held
    run_cmd(3, 2, 0, 0, 10, 1);    // reset in WAIT
    idle_cycles(2);
    run_cmd(5, 1, 11, 0, 0, 0);    // done in cycle 14

    for (int i = 0; i < 25; i++) begin
      s  = int'($urandom_range(0, 15));
      w  = int'($urandom_range(0, 3));
      dc = done_cycle(s, w);
      a  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, dc - 1)) : 0;
      run_cmd(s, w, int'($urandom_range(0, 15)), a, 0, int'($urandom_range(0, 2)));
      idle_cycles(int'($urandom_range(0, 3)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/up_counter_load_seq.md
# up_counter_load_seq

Command sequencer that sits directly upstream of the 4-bit up counter and drives its `load`/`d_in` inputs. It accepts a preload command over a valid/ready handshake and pulses `load` with the start value for one cycle. It then watches the counter's `d_out` for a programmed number of wrap events (all-ones to zero) and signals completion with a one-cycle `done` pulse. It replaces ad-hoc task-driven loading with a reusable control stage.

## Interface
- `WIDTH`, default 4: counter width, matching the counter's `d_in`/`d_out`.
- `WRAP_W`, default 4: width of the wrap-count field.
- `clk` in 1: single clock, all logic on the rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: block can accept a command.
- `cmd_start` in WIDTH: preload value.
- `cmd_wraps` in WRAP_W: number of wrap events to wait for; 0 means none.
- `abort` in 1: cancel the command in flight.
- `load` out 1: counter load strobe.
- `d_in` out WIDTH: counter preload data.
- `cnt` in WIDTH: counter `d_out`.
- `busy` out 1: a command is in flight (states LOAD or WAIT).
- `wrap_seen` out WRAP_W: wraps counted for the current command.
- `done` out 1: one-cycle completion pulse.

## Operation
- FSM states: IDLE, LOAD, WAIT, DONE. State is the only driver of `cmd_ready` (IDLE only), `load` (LOAD only), `busy` (LOAD or WAIT) and `done` (DONE only).
- Reset values:
  - State is IDLE, so `cmd_ready` = 1 and `load`, `busy`, `done` = 0.
  - `d_in` = 0, `wrap_seen` = 0, internal `prev_cnt` = 0, `prev_valid` = 0.
  - Reset asserted mid-command returns to IDLE immediately, with no `done`.
- IDLE: on `cmd_valid && cmd_ready`, capture `cmd_start` into `d_in`, capture `cmd_wraps` into `wraps_q`, clear `wrap_seen`, and go to LOAD.
- LOAD: `load` = 1 for exactly one cycle and `prev_valid` is cleared. Next state is DONE if `wraps_q` == 0, otherwise WAIT.
- WAIT:
  - Every cycle, `prev_cnt` <= `cnt` and `prev_valid` <= 1.
  - Wrap event = `prev_valid && prev_cnt == all-ones && cnt == 0`.
  - On a wrap event, `wrap_seen` increments. If `wrap_seen + 1 == wraps_q`, go to DONE.
- DONE: `done` = 1 for one cycle, then IDLE. `wrap_seen` holds its final value until the next accept.
- The `prev_valid` mask prevents a false wrap when the counter moves from its pre-load value straight to `cmd_start`.
- `d_in` holds the last start value after LOAD; it is not cleared.
- `abort` in LOAD or WAIT: next state IDLE, no `done`. `abort` in IDLE or DONE is ignored.
- Boundary conditions:
  - Abort and a wrap event in the same cycle: abort wins, and `wrap_seen` does not increment.
  - `cmd_valid` while not IDLE: ignored (no accept, no buffering).
  - `cmd_start` = all-ones: the first wrap is detected in the second WAIT cycle.
  - `wrap_seen` arithmetic is WRAP_W-bit; it cannot overflow because it stops at `wraps_q`.

## Timing
- Cycle numbering: the accept edge is E0; cycle k follows edge Ek-1.
- `load` is high in cycle 1. The counter shows `cmd_start` in cycle 2.
- `wraps_q` = 0: `done` is high in cycle 2; a new command can be accepted in cycle 3.
- `wraps_q` = w > 0: the first wrap is detected in cycle 3 + (MAX − start), where MAX = 2^WIDTH − 1. `done` is high in cycle 4 + (MAX − start) + (w − 1)·2^WIDTH.
- `cmd_ready` returns to 1 the cycle after `done`.
- Back-to-back commands are spaced by at least one IDLE cycle.

## Structure
- Shared package `counter_ctrl_pkg`: FSM state encoding (2-bit localparams ST_IDLE/ST_LOAD/ST_WAIT/ST_DONE) and the default WIDTH/WRAP_W constants.
- One sub-module, `count_wrap_detect`, containing `prev_cnt`, `prev_valid` and the wrap-event compare. It has a clear input driven by LOAD and outputs a single-bit `wrap` event.
- FSM, command registers and `wrap_seen` live in the top module.

## Test plan
- Reset then idle:
  - `rst` pulsed high mid-cycle → all outputs at reset values immediately (asynchronous), `cmd_ready` = 1.
  - `load` never asserts without a command.
- start=14, wraps=1, with a model counter attached:
  - `load` = 1 in cycle 1 with `d_in` = 14.
  - `wrap_seen` goes 0→1 at E4.
  - `done` = 1 in cycle 5 only.
- start=15, wraps=0 → `load` in cycle 1, `done` in cycle 2, `wrap_seen` = 0, counter never observed.
- start=0, wraps=2:
  - Counter at 15 before load → no false wrap at the load transition.
  - `done` in cycle 35 (4 + 15 + 16), `wrap_seen` = 2.
- start=12, wraps=3, with `abort` raised in the same cycle as the second wrap:
  - Returns to IDLE, `wrap_seen` = 1, no `done`.
  - `cmd_valid` held high during WAIT is not accepted until IDLE.
- `rst` asserted in WAIT, then released; next command start=5, wraps=1 → normal `done` in cycle 4 + 10 = 14.
